// File: rtl/pwm_bank_pkg.sv
// ============================================================================
// pwm_bank_pkg : register map indices and counter type shared by pwm_bank
// Revision     : 1.0
// ============================================================================
`default_nettype none

package pwm_bank_pkg;
    localparam int REG_CTRL  = 0;
    localparam int REG_PRESC = 1;
    localparam int REG_DUTY0 = 2;

    localparam int CNT_W = 8;
    typedef logic [CNT_W-1:0] cnt_t;
endpackage

`default_nettype wire

// File: rtl/pwm_channel.sv
// ============================================================================
// pwm_channel : one PWM channel, shadow duty register plus output flop
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pwm_channel #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             ch_en,
    input  logic             load,
    input  logic [WIDTH-1:0] duty,
    input  logic [WIDTH-1:0] cnt,
    output logic             pwm_out
);
    logic [WIDTH-1:0] shadow;

    // Shadow only moves at period boundaries so a running period never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow  <= '0;
            pwm_out <= 1'b0;
        end else begin
            if (load) begin
                shadow <= duty;
            end
            pwm_out <= ch_en & ena & (cnt < shadow);
        end
    end
endmodule

`default_nettype wire

// File: rtl/pwm_bank.sv
// ============================================================================
// pwm_bank : shared prescaler/period counter driving NUM_CH PWM channels.
//            Define PWM_BANK_STATUS_EN to expose {wrap_cnt, pwm_out} status.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int WIDTH    = CNT_W,
    parameter int NUM_REGS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic [NUM_REGS*WIDTH-1:0] config_regs,
    output logic [NUM_CH-1:0]         pwm_out,
    output logic                      period_tick,
    output logic [WIDTH-1:0]          status_regs
);
    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [WIDTH-1:0] presc;
    logic [WIDTH-1:0] pre_cnt;
    logic [WIDTH-1:0] cnt;
    logic             step;
    logic             boundary;
    logic             unused_cfg;

    assign presc      = config_regs[REG_PRESC*WIDTH +: WIDTH];
    assign unused_cfg = ^config_regs;

    // ">=" rather than "==" so a lowered prescaler restarts instead of wrapping.
    assign step     = ena & (pre_cnt >= presc);
    assign boundary = step & (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt     <= '0;
            cnt         <= '0;
            period_tick <= 1'b0;
        end else begin
            period_tick <= boundary;
            if (ena) begin
                pre_cnt <= (pre_cnt >= presc) ? '0 : pre_cnt + 1'b1;
            end
            if (step) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pwm_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .ena     (ena),
            .ch_en   (config_regs[REG_CTRL*WIDTH + c]),
            .load    (boundary),
            .duty    (config_regs[(REG_DUTY0+c)*WIDTH +: WIDTH]),
            .cnt     (cnt),
            .pwm_out (pwm_out[c])
        );
    end

`ifdef PWM_BANK_STATUS_EN
    localparam int WRAP_W = WIDTH - NUM_CH;

    logic [WRAP_W-1:0] wrap_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_cnt <= '0;
        end else if (boundary) begin
            wrap_cnt <= wrap_cnt + 1'b1;
        end
    end

    assign status_regs = {wrap_cnt, pwm_out};
`else
    assign status_regs = '0;
`endif
endmodule

`default_nettype wire

// File: tb/tb_pwm_bank.sv
// ============================================================================
// tb_pwm_bank : directed scoreboard bench for pwm_bank (WIDTH=8, NUM_CH=4)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pwm_bank;
    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [63:0] config_regs;
    logic [3:0]  pwm_out;
    logic        period_tick;
    logic [7:0]  status_regs;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   len, hi0, hi1, hi_off, n;

    always #5 clk = ~clk;

    pwm_bank #(
        .NUM_CH   (4),
        .WIDTH    (8),
        .NUM_REGS (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .config_regs (config_regs),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .status_regs (status_regs)
    );

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty observed=%0d", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic set_reg(input int idx, input logic [7:0] val);
        config_regs[idx*8 +: 8] = val;
    endtask

    // Cycles until the next period_tick; 0 if it never arrives.
    task automatic wait_tick(output int cycles);
        cycles = 0;
        for (int k = 1; k <= 4000; k++) begin
            @(negedge clk);
            if (period_tick) begin
                cycles = k;
                break;
            end
        end
    endtask

    // Starts on a tick cycle; counts one full period up to and including the next tick.
    task automatic measure(input int mod_at, input int mod_reg, input int mod_val,
                           input int off_at, output int plen, output int h0,
                           output int h1, output int hoff);
        plen = 0; h0 = 0; h1 = 0; hoff = 0;
        for (int k = 1; k <= 5000; k++) begin
            @(negedge clk);
            plen = k;
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
            if (off_at >= 0 && k > off_at && k <= off_at + 50) hoff += int'(|pwm_out);
            if (period_tick) break;
            if (k == mod_at) set_reg(mod_reg, mod_val[7:0]);
            if (k == off_at) ena = 1'b0;
            if (off_at >= 0 && k == off_at + 50) ena = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1;
        ena = 1'b1;
        config_regs = '0;
        set_reg(0, 8'h01);
        set_reg(1, 8'd0);
        set_reg(2, 8'd64);
        set_reg(3, 8'd200);
        repeat (3) @(negedge clk);
        push("rst_pwm", 0);    check(32'(pwm_out));
        push("rst_tick", 0);   check(32'(period_tick));
        push("rst_status", 0); check(32'(status_regs));

        rst = 1'b0;
        push("first_tick_latency", 255);
        wait_tick(n); check(32'(n));

        push("p1_len", 255); push("p1_hi", 64); push("p1_ch1_disabled", 0);
        measure(-1, 0, 0, -1, len, hi0, hi1, hi_off);
        check(32'(len)); check(32'(hi0)); check(32'(hi1));

        push("midwrite_cur_hi", 64);
        measure(100, 2, 200, -1, len, hi0, hi1, hi_off); check(32'(hi0));
        push("midwrite_next_hi", 200);
        measure(10, 2, 0, -1, len, hi0, hi1, hi_off);    check(32'(hi0));
        push("duty0_hi", 0);
        measure(10, 2, 255, -1, len, hi0, hi1, hi_off);  check(32'(hi0));
        push("chan_disable_hi", 10);
        measure(10, 0, 0, -1, len, hi0, hi1, hi_off);    check(32'(hi0));
        push("disabled_hi", 0);
        measure(5, 2, 30, -1, len, hi0, hi1, hi_off);    check(32'(hi0));
        push("reenable_hi", 25);
        measure(5, 0, 1, -1, len, hi0, hi1, hi_off);     check(32'(hi0));
        push("shadow_while_off_hi", 30);
        measure(5, 2, 64, -1, len, hi0, hi1, hi_off);    check(32'(hi0));

        push("ena_gap_len", 305); push("ena_gap_hi", 64); push("ena_gap_low", 0);
        measure(-1, 0, 0, 20, len, hi0, hi1, hi_off);
        check(32'(len)); check(32'(hi0)); check(32'(hi_off));

        set_reg(2, 8'd128);
        measure(5, 1, 3, -1, len, hi0, hi1, hi_off);
        push("presc3_len", 1020); push("presc3_hi", 512);
        measure(5, 2, 200, -1, len, hi0, hi1, hi_off);
        check(32'(len)); check(32'(hi0));

        repeat (600) @(negedge clk);
        push("pre_rst_pwm0", 1); check(32'(pwm_out[0]));
        rst = 1'b1;
        @(negedge clk);
        push("midrst_pwm", 0);    check(32'(pwm_out));
        push("midrst_tick", 0);   check(32'(period_tick));
        push("midrst_status", 0); check(32'(status_regs));
        rst = 1'b0;
        push("post_rst_tick_latency", 1020);
        wait_tick(n); check(32'(n));
        wait_tick(n);
        wait_tick(n);
`ifdef PWM_BANK_STATUS_EN
        push("wrap_after_3", 3); check(32'(status_regs[7:4]));
`else
        push("status_const0", 0); check(32'(status_regs));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 Parameter NUM_CH, default 4: number of PWM channels, 1..WIDTH-1.
REQ-002 Parameter WIDTH, default 8: register and counter width.
REQ-003 Parameter NUM_REGS, default 8: registers in the packed config bus, at least NUM_CH+2.
REQ-004 Port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port ena, input, 1: block enable, from the design-level enable.
REQ-007 Port config_regs, input, NUM_REGS*WIDTH: packed register bank from the SPI register wrapper; register k occupies bits [(k+1)*WIDTH-1 : k*WIDTH].
REQ-008 Port pwm_out, output, NUM_CH: registered PWM outputs.
REQ-009 Port period_tick, output, 1: one-cycle pulse at each PWM period boundary.
REQ-010 Port status_regs, output, WIDTH: status word fed back to the SPI register wrapper.

Function
REQ-011 Register map: reg0 holds the channel enables, bit c enabling channel c; reg1 holds the prescaler P; reg2+c holds the duty D for channel c; other registers are ignored.
REQ-012 Prescaler counter pre_cnt SHALL count 0..P; step asserts in the cycle where pre_cnt >= P, and pre_cnt returns to 0 on the next cycle, otherwise it increments.
REQ-013 P=0 SHALL give step every cycle.
REQ-014 If P is lowered below the current pre_cnt, pre_cnt SHALL return to 0 on the next cycle (no wrap through 2^WIDTH).
REQ-015 Period counter cnt SHALL advance on step through 0..2^WIDTH-2 (255 steps for WIDTH=8), then wrap to 0.
REQ-016 Boundary: step with cnt == 2^WIDTH-2.
REQ-017 period_tick SHALL be asserted for exactly the cycle following the boundary.
REQ-018 Each channel SHALL keep a shadow duty register, loaded from reg2+c only at the boundary, so config writes never glitch a running period.
REQ-019 The boundary SHALL load all shadows in the same cycle.
REQ-020 pwm_out[c] on the next cycle SHALL be 1 iff channel enable c=1, ena=1 and cnt < shadow_c.
REQ-021 Output latency: exactly one clk cycle from a cnt/shadow change to pwm_out.
REQ-022 D=0 SHALL give a constant low output.
REQ-023 D=2^WIDTH-1 SHALL give a constant high output.
REQ-024 Any intermediate D SHALL give D high steps per 2^WIDTH-1 steps.
REQ-025 Clearing a channel enable SHALL force that output low on the next cycle; its shadow SHALL keep updating at boundaries.
REQ-026 ena=0 SHALL freeze pre_cnt, cnt, the shadows and the wrap counter, force pwm_out low and suppress period_tick.
REQ-027 When ena returns to 1, counting SHALL resume from the frozen values.
REQ-028 Wrap counter wrap_cnt, WIDTH-NUM_CH bits, SHALL increment modulo its width at every boundary.

Reset
REQ-029 While rst=1, the following SHALL be 0 on the next edge: pre_cnt, cnt, all shadows, wrap_cnt, pwm_out, period_tick, status_regs.
REQ-030 rst SHALL take priority over ena and over the boundary.
REQ-031 Reset mid-period SHALL abort that period; the first post-reset boundary occurs (2^WIDTH-1)*(P+1) cycles after rst deasserts.

Configuration
REQ-032 Macro PWM_BANK_STATUS_EN defined: status_regs is registered as {wrap_cnt, pwm_out}.
REQ-033 Macro PWM_BANK_STATUS_EN undefined: status_regs is constant 0, and wrap_cnt is not implemented.

Structure
REQ-034 Shared package pwm_bank_pkg SHALL hold the register index constants (REG_CTRL=0, REG_PRESC=1, REG_DUTY0=2) and the counter-width typedef.
REQ-035 One sub-module, pwm_channel, SHALL be instantiated NUM_CH times; each instance holds the shadow register and output flop for one channel.
REQ-036 The prescaler and period counter SHALL be shared in pwm_bank.

Verification
REQ-037 Set reg0=0x01, reg1=0, reg2=64 from reset: pwm_out[0] is high for 64 cycles out of every 255, and period_tick has period 255.
REQ-038 Set reg1=3, reg2=128: pwm_out[0] has a period of 1020 cycles with 512 high, and period_tick occurs every 1020 cycles.
REQ-039 Write reg2 from 64 to 200 at cnt=100: the current period is unchanged (low from cnt 64), and the next period is high for 200 steps.
REQ-040 Set reg2=0 then reg2=255: output is constantly low, then constantly high from the next boundary.
REQ-041 ena low for 50 cycles mid-period: outputs are low and no tick occurs; on resume, the period completes with its total enabled cycle count preserved.
REQ-042 rst pulse at cnt=150: all outputs are 0 the next cycle, and the first tick occurs 255*(P+1) cycles later.
REQ-043 With PWM_BANK_STATUS_EN defined, status_regs[7:4]=3 after 3 boundaries.
